// File: rtl/ub_affine_port_scheduler.sv
// Iteration-domain scheduler for a two-port unified buffer. It walks a 3-level loop nest
// on the write port, then replays the same sequence on the read port RD_DELAY active cycles later.
module ub_affine_port_scheduler #(
   parameter int unsigned EXT0     = 1,
   parameter int unsigned EXT1     = 64,
   parameter int unsigned EXT2     = 64,
   parameter int unsigned II       = 1,
   parameter int unsigned WR_START = 0,
   parameter int unsigned RD_DELAY = 2,
   parameter int unsigned CW       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                start,
   input  logic                stall,
   output logic                wr_wen,
   output logic [2:0][CW-1:0]  wr_ctrl_vars,
   output logic                rd_ren,
   output logic [2:0][CW-1:0]  rd_ctrl_vars,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DRAIN} state_e;
   typedef logic [2:0][CW-1:0] vars_t;

   typedef struct packed {
      state_e        state;
      logic [CW-1:0] pre;
      vars_t         wr_cnt;
      vars_t         rd_cnt;
      logic [CW-1:0] wr_ph;
      logic [CW-1:0] rd_ph;
      logic [CW-1:0] rd_wait;
      logic          wr_left;
      logic          rd_left;
      logic          rd_arm;
      logic          wr_wen;
      logic          rd_ren;
      logic          busy;
      logic          done;
      vars_t         wr_vars;
      vars_t         rd_vars;
   } regs_t;

   regs_t r_q, r_d;
   logic  active_c, accept_c, launch_c, wr_en_c, rd_en_c;
   logic  wr_fire_c, rd_fire_c, wr_last_c, rd_last_c;

   // Advance the nest: [1] fastest, carry into [2], then into [0].
   function automatic vars_t nest_next(input vars_t c);
      vars_t n;
      n = c;
      if (c[1] != CW'(EXT1 - 1)) begin
         n[1] = c[1] + CW'(1);
      end else begin
         n[1] = '0;
         if (c[2] != CW'(EXT2 - 1)) begin
            n[2] = c[2] + CW'(1);
         end else begin
            n[2] = '0;
            n[0] = (c[0] == CW'(EXT0 - 1)) ? '0 : c[0] + CW'(1);
         end
      end
      return n;
   endfunction

   function automatic logic nest_last(input vars_t c);
      return (c[0] == CW'(EXT0 - 1)) && (c[1] == CW'(EXT1 - 1)) && (c[2] == CW'(EXT2 - 1));
   endfunction

   always_comb begin
      r_d       = r_q;
      active_c  = !stall;
      accept_c  = active_c && (r_q.state == S_IDLE) && start;
      // The first write decision is taken in the last pre-run cycle so wen lands right after it.
      launch_c  = (accept_c && (WR_START == 0)) ||
                  ((r_q.state == S_PRE) && (r_q.pre == CW'(WR_START - 1)));
      wr_en_c   = (r_q.state == S_RUN) || launch_c;
      rd_en_c   = r_q.rd_arm && (r_q.rd_wait == '0);
      wr_fire_c = active_c && wr_en_c && (r_q.wr_left || accept_c) && (r_q.wr_ph == '0);
      rd_fire_c = active_c && rd_en_c && r_q.rd_left && (r_q.rd_ph == '0);
      wr_last_c = nest_last(r_q.wr_cnt);
      rd_last_c = nest_last(r_q.rd_cnt);

      if (active_c) begin
         r_d.wr_wen = wr_fire_c;
         r_d.rd_ren = rd_fire_c;
         r_d.done   = 1'b0;

         case (r_q.state)
            S_IDLE: begin
               if (accept_c) begin
                  r_d.busy    = 1'b1;
                  r_d.wr_left = 1'b1;
                  r_d.pre     = '0;
                  r_d.state   = S_PRE;
               end
            end
            S_PRE: begin
               if (!launch_c) r_d.pre = r_q.pre + CW'(1);
            end
            default: ;
         endcase
         if (launch_c) r_d.state = S_RUN;

         if (wr_fire_c) begin
            r_d.wr_vars = r_q.wr_cnt;
            r_d.wr_cnt  = nest_next(r_q.wr_cnt);
            r_d.wr_ph   = CW'(II - 1);
            if (wr_last_c) begin
               r_d.wr_left = 1'b0;
               r_d.state   = S_DRAIN;
            end
            if (!r_q.rd_arm) begin
               r_d.rd_arm  = 1'b1;
               r_d.rd_left = 1'b1;
               r_d.rd_wait = CW'(RD_DELAY - 1);
            end
         end else if (wr_en_c && (r_q.wr_ph != '0)) begin
            r_d.wr_ph = r_q.wr_ph - CW'(1);
         end

         if (r_q.rd_arm && (r_q.rd_wait != '0)) r_d.rd_wait = r_q.rd_wait - CW'(1);

         if (rd_fire_c) begin
            r_d.rd_vars = r_q.rd_cnt;
            r_d.rd_cnt  = nest_next(r_q.rd_cnt);
            r_d.rd_ph   = CW'(II - 1);
            if (rd_last_c) r_d.rd_left = 1'b0;
         end else if (rd_en_c && (r_q.rd_ph != '0)) begin
            r_d.rd_ph = r_q.rd_ph - CW'(1);
         end

         // Last read has been presented: retire, keeping the final ctrl_vars visible.
         if ((r_q.state == S_DRAIN) && !r_q.rd_left) begin
            r_d         = '0;
            r_d.wr_vars = r_q.wr_vars;
            r_d.rd_vars = r_q.rd_vars;
            r_d.done    = 1'b1;
         end
      end

      if (flush) r_d = '0;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) r_q <= '0;
      else       r_q <= r_d;
   end

   // Issue and done slots are held through a stall and only presented on unstalled cycles.
   assign wr_wen       = r_q.wr_wen & ~stall;
   assign rd_ren       = r_q.rd_ren & ~stall;
   assign done         = r_q.done & ~stall;
   assign busy         = r_q.busy;
   assign wr_ctrl_vars = r_q.wr_vars;
   assign rd_ctrl_vars = r_q.rd_vars;

endmodule

// File: doc/ub_affine_port_scheduler.md
Name: ub_affine_port_scheduler

Overview:
- Iteration-domain controller for a two-port unified buffer with one write op and one read op, as in the pointwise hw_input/mult buffers.
- Walks a 3-level loop nest and drives the write port's wen/ctrl_vars, then the read port's ren/ctrl_vars.
- The read sequence replays the write sequence a fixed number of active cycles later.
- Sits between the pipeline top-level start logic and a *_ub instance.

Parameters:
- EXT0, 1, extent of ctrl_vars[0] (outermost loop)
- EXT1, 64, extent of ctrl_vars[1] (innermost loop, unit address stride)
- EXT2, 64, extent of ctrl_vars[2] (middle loop, row stride)
- II, 1, initiation interval in active cycles between issues (>=1)
- WR_START, 0, active cycles from start to first write issue
- RD_DELAY, 2, active cycles from write issue n to read issue n (>=1)
- CW, 16, width of each ctrl_var and internal counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high (asserted = 1)
- flush  in  1  synchronous abort/restart to IDLE, same-cycle priority over everything except reset
- start  in  1  one-cycle pulse, accepted only in IDLE
- stall  in  1  freezes all counters and state; wen/ren forced 0 while high
- wr_wen  out  1  write-port enable (to op_*_write_wen)
- wr_ctrl_vars  out  3xCW  write iteration vars [2:0]
- rd_ren  out  1  read-port enable (to op_*_read_ren)
- rd_ctrl_vars  out  3xCW  read iteration vars [2:0]
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last read issue

Behaviour:
- Reset: state IDLE; all counters 0; wr_wen=0, rd_ren=0, busy=0, done=0; ctrl_vars outputs 0.
- Active cycle: a cycle with stall=0. All delays and intervals below count active cycles only.
- Loop order: ctrl_vars[1] fastest (0..EXT1-1), then [2] (0..EXT2-1), then [0] (0..EXT0-1). N = EXT0*EXT1*EXT2 issues per port.
- Write and read each use an independent 3-level counter nest with an II phase counter.
- Issue rule: a port issues when its phase counter is 0 and remaining > 0.
  - wen/ren is registered and asserted in the issue cycle with the matching ctrl_vars.
  - ctrl_vars hold their last value between issues.
- States:
  - IDLE: start (and flush=0) -> PRE; busy goes 1 the next cycle.
  - PRE: counts WR_START active cycles, then -> RUN. With WR_START=0, the first wr_wen is asserted the cycle after start.
  - RUN: the write nest issues N times.
    - The read-launch counter starts at the first write issue; the first rd_ren occurs exactly RD_DELAY active cycles after the first wr_wen.
    - Since both nests share II and stall, read issue n always lags write issue n by RD_DELAY.
    - After the last write issue -> DRAIN.
  - DRAIN: only the read nest advances. After the last read issue, done pulses the next cycle, busy drops the same cycle as done -> IDLE.
  - If RD_DELAY is shorter than the write tail, reads may issue while in RUN. This is legal; the DRAIN transition still follows the last write.
- Wrap-around: when a var reaches extent-1 and advances, it goes to 0 and carries into the next var. The final issue has vars = {EXT0-1, EXT2-1, EXT1-1} in index order [0],[2],[1]. Counters never exceed extent-1.
- start while busy: ignored.
- start and flush in the same cycle: flush wins, stays IDLE.
- flush mid-operation: next cycle IDLE, counters 0, wen/ren 0, no done pulse.
- stall mid-operation:
  - wen/ren are 0 in stalled cycles.
  - On release, the issue that would have occurred fires in the first unstalled cycle with unchanged ctrl_vars.
- stall during the done cycle: done still pulses exactly once, on the first unstalled cycle.
- Asynchronous reset mid-operation: immediate return to reset values.
- Arithmetic: unsigned CW-bit. Extents are compile-time values with 1 <= EXT <= 2^CW-1.

Test Plan:
- Basic (EXT0=1, EXT1=4, EXT2=2, II=1, WR_START=0, RD_DELAY=2), start at cycle 0:
  - wr_wen high cycles 1-8, vars[1] 0,1,2,3,0,1,2,3 and vars[2] 0,0,0,0,1,1,1,1.
  - rd_ren high cycles 3-10 with the identical sequence.
  - done pulses at cycle 11; busy high cycles 1-10.
- II=2, WR_START=3, same extents: first wr_wen at cycle 4, then every 2nd cycle, 8 issues (last at cycle 18); reads at cycle 6 through cycle 20; done at 21.
- Stall with the basic config, stall high cycles 4-6:
  - No wen/ren in cycles 4-6.
  - Write issue 4 (vars[1]=3) fires at cycle 7.
  - Read lag stays 2; done shifts to cycle 14.
- Flush at cycle 5 of the basic config:
  - wen/ren 0 from cycle 6, busy 0, no done.
  - A new start at cycle 8 reproduces the full basic sequence offset by 8.
- start pulsed while busy, and start+flush together in IDLE: both ignored, outputs unchanged.
- Reset asserted mid-RUN: outputs 0 asynchronously.
- Full-size default (EXT 1x64x64): exactly 4096 wen and 4096 ren.
  - Final write vars {0,63,63}; final read exactly 2 active cycles after final write.
  - Scoreboard check: RAM address vars[1]+64*vars[2] covers 0..4095 once per port.
